// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/Mux2in16bits.sv
// Plain 2:1 word mux used to steer the winner's address and write data to memory.
module Mux2in16bits #(
  parameter int W = 16
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic         sel,
  output logic [W-1:0] out_y
);

  assign out_y = sel ? in1 : in0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (0) and load/store (1).
// Optional bounded-wait abort is enabled with the MEM_ARB_TIMEOUT_EN macro.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
`ifdef MEM_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = DEF_TIMEOUT
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we0,
  input  logic              we1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output state_e            dbg_state
);

  // Handshake: a requester holds req (and its fields) until its one-cycle done;
  // the memory sees mem_en for the whole access and ends it with mem_ready.

  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic              last_q, last_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              busy, elig0, elig1, we_sel, finish;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  assign busy = (state_q == ST_BUSY);
  // A req still high during its own done cycle belongs to the finished access.
  assign elig0  = req0 & ~done0_q;
  assign elig1  = req1 & ~done1_q;
  assign we_sel = sel_q ? we1 : we0;

  Mux2in16bits #(.W(ADDR_W)) u_addr_mux (
    .in0   (addr0),
    .in1   (addr1),
    .sel   (sel_q),
    .out_y (mem_addr)
  );

  Mux2in16bits #(.W(DATA_W)) u_wdata_mux (
    .in0   (wdata0),
    .in1   (wdata1),
    .sel   (sel_q),
    .out_y (mem_wdata)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    rdata_d = rdata_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    finish  = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (elig0 || elig1) begin
          sel_d   = (elig0 && elig1) ? ~last_q : elig1;
          state_d = ST_BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          finish  = 1'b1;
          rdata_d = we_sel ? '0 : mem_rdata;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          finish  = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
        if (finish) begin
          done0_d = ~sel_q;
          done1_d = sel_q;
          last_d  = sel_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      rdata_q <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign gnt0      = busy & ~sel_q;
  assign gnt1      = busy & sel_q;
  assign mem_en    = busy;
  assign mem_we    = busy & we_sel;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign rdata     = rdata_q;
  assign dbg_state = state_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand sequences, and a
// randomized run against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int TB_TIMEOUT = 4;
  localparam int N_VEC      = 11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, err, mem_en, mem_we;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  state_e      dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .DATA_W (16),
    .ADDR_W (16)
`ifdef MEM_ARB_TIMEOUT_EN
    , .TIMEOUT (TB_TIMEOUT)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .we0       (we0),
    .we1       (we1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .done0     (done0),
    .done1     (done1),
    .rdata     (rdata),
    .err       (err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .dbg_state (dbg_state)
  );

  typedef struct {
    logic        r0, r1, w0, w1;
    logic [15:0] a0, a1, d0, d1;
    logic        rdy;
    logic [15:0] mrd;
    logic [3:0]  ctl;   // {gnt0, gnt1, mem_en, mem_we}
    logic [1:0]  dn;    // {done0, done1}
    logic [15:0] ea, ew, er;
  } vec_t;

  vec_t vecs[N_VEC];

  function automatic vec_t mk(input logic r0, r1, w0, w1,
                              input logic [15:0] a0, a1, d0, d1,
                              input logic rdy, input logic [15:0] mrd,
                              input logic [3:0] ctl, input logic [1:0] dn,
                              input logic [15:0] ea, ew, er);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.rdy = rdy; v.mrd = mrd;
    v.ctl = ctl; v.dn = dn; v.ea = ea; v.ew = ew; v.er = er;
    return v;
  endfunction

  function automatic logic [6:0] ctl_now();
    return {gnt0, gnt1, mem_en, mem_we, done0, done1, err};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_exp(input string tag, input logic [3:0] ctl, input logic [1:0] dn,
                           input logic err_e, input logic [15:0] ea, ew, er);
    chk({tag, "_ctl"}, {25'd0, ctl_now()}, {25'd0, ctl, dn, err_e});
    if (ctl[1]) chk({tag, "_addr"}, {16'd0, mem_addr}, {16'd0, ea});
    if (ctl[1] && ctl[0]) chk({tag, "_wdata"}, {16'd0, mem_wdata}, {16'd0, ew});
    if (dn != 2'b00) chk({tag, "_rdata"}, {16'd0, rdata}, {16'd0, er});
  endtask

  task automatic drive(input logic r0, r1, w0, w1, input logic [15:0] a0, a1, d0, d1,
                       input logic rdy, input logic [15:0] mrd);
    req0 = r0; req1 = r1; we0 = w0; we1 = w1;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    mem_ready = rdy; mem_rdata = mrd;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_outs"}, {25'd0, ctl_now()}, 32'd0);
    chk({tag, "_rdata"}, {16'd0, rdata}, 32'd0);
    chk({tag, "_state"}, {31'd0, dbg_state}, {31'd0, ST_IDLE});
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 16'h0);
    @(posedge clk); #1;
    check_reset("reset");
    rst_n = 1'b1;
  endtask

  // Reference model state (transaction level).
  int          m_owner, m_done, m_last, m_wait, nd;
  logic        m_err, nerr, rdy, busy, own_we, e0, e1;
  logic [15:0] m_rdata, mrd;
  logic        r_req[2], r_we[2];
  logic [15:0] r_addr[2], r_wdata[2];

  task automatic new_req(input int i);
    r_req[i]   = 1'b1;
    r_we[i]    = 1'($urandom_range(0, 1));
    r_addr[i]  = 16'($urandom);
    r_wdata[i] = 16'($urandom);
  endtask

  initial begin
    vecs[0]  = mk(1, 0, 0, 0, 16'h0239, 16'h0, 16'h0, 16'h0,    0, 16'h0000, 4'b0000, 2'b00, 16'h0, 16'h0, 16'h0);
    vecs[1]  = mk(1, 0, 0, 0, 16'h0239, 16'h0, 16'h0, 16'h0,    1, 16'h00E3, 4'b1010, 2'b00, 16'h0239, 16'h0, 16'h0);
    vecs[2]  = mk(1, 0, 0, 0, 16'h0239, 16'h0, 16'h0, 16'h0,    0, 16'h0000, 4'b0000, 2'b10, 16'h0, 16'h0, 16'h00E3);
    vecs[3]  = mk(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0,       0, 16'h0000, 4'b0000, 2'b00, 16'h0, 16'h0, 16'h0);
    vecs[4]  = mk(0, 1, 0, 1, 16'h0, 16'h0040, 16'h0, 16'hBEEF, 0, 16'h0000, 4'b0000, 2'b00, 16'h0, 16'h0, 16'h0);
    vecs[5]  = mk(0, 1, 0, 1, 16'h0, 16'h0040, 16'h0, 16'hBEEF, 0, 16'h0000, 4'b0111, 2'b00, 16'h0040, 16'hBEEF, 16'h0);
    vecs[6]  = mk(0, 1, 0, 1, 16'h0, 16'h0040, 16'h0, 16'hBEEF, 0, 16'h0000, 4'b0111, 2'b00, 16'h0040, 16'hBEEF, 16'h0);
    vecs[7]  = mk(0, 1, 0, 1, 16'h0, 16'h0040, 16'h0, 16'hBEEF, 0, 16'h0000, 4'b0111, 2'b00, 16'h0040, 16'hBEEF, 16'h0);
    vecs[8]  = mk(0, 1, 0, 1, 16'h0, 16'h0040, 16'h0, 16'hBEEF, 1, 16'h1234, 4'b0111, 2'b00, 16'h0040, 16'hBEEF, 16'h0);
    vecs[9]  = mk(0, 1, 0, 1, 16'h0, 16'h0040, 16'h0, 16'hBEEF, 1, 16'h5555, 4'b0000, 2'b01, 16'h0, 16'h0, 16'h0);
    vecs[10] = mk(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0,       1, 16'h6666, 4'b0000, 2'b00, 16'h0, 16'h0, 16'h0);

    // Directed single read then single write with three wait cycles.
    do_reset();
    for (int i = 0; i < N_VEC; i++) begin
      drive(vecs[i].r0, vecs[i].r1, vecs[i].w0, vecs[i].w1, vecs[i].a0, vecs[i].a1,
            vecs[i].d0, vecs[i].d1, vecs[i].rdy, vecs[i].mrd);
      @(negedge clk);
      check_exp($sformatf("vec%0d", i), vecs[i].ctl, vecs[i].dn, 1'b0, vecs[i].ea, vecs[i].ew, vecs[i].er);
      @(posedge clk); #1;
    end

    // Contention: both requesters held, zero-wait memory; last cycle stalls mid-access.
    do_reset();
    for (int k = 0; k < 14; k++) begin
      int own;
      drive(1, 1, 0, 0, 16'hA000, 16'hB000, 16'h0, 16'h0, (k != 13), 16'(16'h0100 + k));
      @(negedge clk);
      if (k == 0) begin
        check_exp("cont_idle", 4'b0000, 2'b00, 1'b0, 16'h0, 16'h0, 16'h0);
      end else if (k % 2 == 1) begin
        own = ((k - 1) / 2) % 2;
        check_exp($sformatf("cont_busy%0d", k), (own == 1) ? 4'b0110 : 4'b1010, 2'b00, 1'b0,
                  (own == 1) ? 16'hB000 : 16'hA000, 16'h0, 16'h0);
      end else begin
        own = ((k - 2) / 2) % 2;
        check_exp($sformatf("cont_done%0d", k), 4'b0000, (own == 1) ? 2'b01 : 2'b10, 1'b0,
                  16'h0, 16'h0, 16'(16'h0100 + k - 1));
      end
      if (k != 13) begin
        @(posedge clk); #1;
      end
    end
    // Asynchronous reset in the middle of a BUSY cycle.
    #2 rst_n = 1'b0;
    #1 check_reset("midbusy_rst");
    drive(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 16'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_exp("post_rst", 4'b0000, 2'b00, 1'b0, 16'h0, 16'h0, 16'h0);
    @(posedge clk); #1;

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: abort after TB_TIMEOUT busy cycles, then a normal access.
    for (int k = 0; k <= TB_TIMEOUT + 3; k++) begin
      if (k <= TB_TIMEOUT) drive(1, 0, 0, 0, 16'h0777, 16'h0, 16'h0, 16'h0, 0, 16'hDEAD);
      else drive(0, 1, 0, 0, 16'h0, 16'h0999, 16'h0, 16'h0, 1, 16'h7777);
      @(negedge clk);
      if (k == 0) check_exp("to_idle", 4'b0000, 2'b00, 1'b0, 16'h0, 16'h0, 16'h0);
      else if (k <= TB_TIMEOUT) check_exp("to_busy", 4'b1010, 2'b00, 1'b0, 16'h0777, 16'h0, 16'h0);
      else if (k == TB_TIMEOUT + 1) check_exp("to_abort", 4'b0000, 2'b10, 1'b1, 16'h0, 16'h0, 16'h0);
      else if (k == TB_TIMEOUT + 2) check_exp("to_next", 4'b0110, 2'b00, 1'b0, 16'h0999, 16'h0, 16'h0);
      else check_exp("to_next_done", 4'b0000, 2'b01, 1'b0, 16'h0, 16'h0, 16'h7777);
      @(posedge clk); #1;
    end
`else
    // Memory silent for 50 cycles: the access simply waits, then completes.
    for (int k = 0; k < 53; k++) begin
      drive((k < 52), 0, 0, 0, 16'h0777, 16'h0, 16'h0, 16'h0, (k == 51), 16'h4242);
      @(negedge clk);
      if (k == 0) check_exp("wait_idle", 4'b0000, 2'b00, 1'b0, 16'h0, 16'h0, 16'h0);
      else if (k < 52) check_exp("wait_busy", 4'b1010, 2'b00, 1'b0, 16'h0777, 16'h0, 16'h0);
      else check_exp("wait_done", 4'b0000, 2'b10, 1'b0, 16'h0, 16'h0, 16'h4242);
      @(posedge clk); #1;
    end
`endif

    // Randomized traffic against the transaction-level model.
    do_reset();
    m_owner = -1; m_done = -1; m_last = 1; m_wait = 0; m_err = 1'b0; m_rdata = 16'h0;
    for (int i = 0; i < 2; i++) begin
      r_req[i] = 1'b0; r_we[i] = 1'b0; r_addr[i] = 16'h0; r_wdata[i] = 16'h0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rdy = ($urandom_range(0, 3) != 0);
      mrd = 16'($urandom);
      drive(r_req[0], r_req[1], r_we[0], r_we[1], r_addr[0], r_addr[1],
            r_wdata[0], r_wdata[1], rdy, mrd);
      @(negedge clk);
      busy   = (m_owner >= 0);
      own_we = busy ? r_we[m_owner] : 1'b0;
      check_exp("rnd", {busy && m_owner == 0, busy && m_owner == 1, busy, own_we},
                {m_done == 0, m_done == 1}, m_err,
                busy ? r_addr[m_owner] : 16'h0, busy ? r_wdata[m_owner] : 16'h0, m_rdata);
      nd = -1; nerr = 1'b0;
      if (busy) begin
        if (rdy) begin
          nd = m_owner;
          m_rdata = own_we ? 16'h0 : mrd;
        end else begin
          m_wait++;
`ifdef MEM_ARB_TIMEOUT_EN
          if (m_wait == TB_TIMEOUT) begin
            nd = m_owner; nerr = 1'b1; m_rdata = 16'h0;
          end
`endif
        end
        if (nd >= 0) begin
          m_last = m_owner;
          m_owner = -1;
        end
      end else begin
        e0 = r_req[0] && (m_done != 0);
        e1 = r_req[1] && (m_done != 1);
        if (e0 && e1) m_owner = 1 - m_last;
        else if (e0) m_owner = 0;
        else if (e1) m_owner = 1;
        m_wait = 0;
      end
      m_done = nd;
      m_err  = nerr;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (m_done == i) begin
          if ($urandom_range(0, 1) == 1) new_req(i);
          else r_req[i] = 1'b0;
        end else if (!r_req[i] && $urandom_range(0, 2) == 0) begin
          new_req(i);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
